// File: rtl/ir_pipe_ctrl.sv
// IR/PC/valid pipeline register chain (DEC, EXE, MEM, WB) for the 5-stage OTTER, with
// load-use stall detection, decode-stage flush and saturating stall/flush event counters.
module ir_pipe_ctrl #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013,
    parameter int          CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      IF_IR,
    input  logic [31:0]      IF_PC,
    input  logic             IF_VALID,
    input  logic             FLUSH,
    output logic             STALL,
    output logic [31:0]      DEC_IR,
    output logic [31:0]      DEC_PC,
    output logic [31:0]      EXE_IR,
    output logic [31:0]      EXE_PC,
    output logic [31:0]      MEM_IR,
    output logic [31:0]      MEM_PC,
    output logic [31:0]      WB_IR,
    output logic [31:0]      WB_PC,
    output logic             DEC_IR_EN,
    output logic             EXE_IR_EN,
    output logic             MEM_IR_EN,
    output logic             WB_IR_EN,
    output logic [CNT_W-1:0] STALL_COUNT,
    output logic [CNT_W-1:0] FLUSH_COUNT
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    logic [6:0] opc_d;
    logic [2:0] f3_d;
    logic [4:0] rs1_d;
    logic [4:0] rs2_d;
    logic [4:0] rd_e;
    logic       use_rs1;
    logic       use_rs2;
    logic       load_e;

    assign opc_d  = DEC_IR[6:0];
    assign f3_d   = DEC_IR[14:12];
    assign rs1_d  = DEC_IR[19:15];
    assign rs2_d  = DEC_IR[24:20];
    assign rd_e   = EXE_IR[11:7];
    assign load_e = EXE_IR_EN && (EXE_IR[6:0] == OPC_LOAD) && (rd_e != 5'd0);

    // Source-register usage of the instruction sitting in DEC; LUI/AUIPC/JAL read nothing.
    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opc_d)
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: use_rs1 = 1'b1;
            OPC_BRANCH, OPC_STORE, OPC_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_SYSTEM: use_rs1 = (f3_d == 3'd1) || (f3_d == 3'd2) || (f3_d == 3'd3);
            default: begin
                use_rs1 = 1'b0;
                use_rs2 = 1'b0;
            end
        endcase
    end

    assign STALL = load_e && DEC_IR_EN &&
                   ((use_rs1 && (rs1_d == rd_e)) || (use_rs2 && (rs2_d == rd_e)));

    always_ff @(posedge CLK) begin
        if (RST) begin
            DEC_IR      <= NOP_INSTR;
            DEC_PC      <= 32'd0;
            DEC_IR_EN   <= 1'b0;
            EXE_IR      <= NOP_INSTR;
            EXE_PC      <= 32'd0;
            EXE_IR_EN   <= 1'b0;
            MEM_IR      <= NOP_INSTR;
            MEM_PC      <= 32'd0;
            MEM_IR_EN   <= 1'b0;
            WB_IR       <= NOP_INSTR;
            WB_PC       <= 32'd0;
            WB_IR_EN    <= 1'b0;
            STALL_COUNT <= '0;
            FLUSH_COUNT <= '0;
        end else begin
            WB_IR     <= MEM_IR;
            WB_PC     <= MEM_PC;
            WB_IR_EN  <= MEM_IR_EN;
            MEM_IR    <= EXE_IR;
            MEM_PC    <= EXE_PC;
            MEM_IR_EN <= EXE_IR_EN;
            if (STALL) begin
                // DEC holds; the load moves on and a bubble opens behind it.
                EXE_IR    <= NOP_INSTR;
                EXE_PC    <= 32'd0;
                EXE_IR_EN <= 1'b0;
                if (STALL_COUNT != {CNT_W{1'b1}}) begin
                    STALL_COUNT <= STALL_COUNT + 1'b1;
                end
            end else begin
                EXE_IR    <= DEC_IR;
                EXE_PC    <= DEC_PC;
                EXE_IR_EN <= DEC_IR_EN;
                if (FLUSH || !IF_VALID) begin
                    DEC_IR    <= NOP_INSTR;
                    DEC_PC    <= 32'd0;
                    DEC_IR_EN <= 1'b0;
                end else begin
                    DEC_IR    <= IF_IR;
                    DEC_PC    <= IF_PC;
                    DEC_IR_EN <= 1'b1;
                end
                if (FLUSH && (FLUSH_COUNT != {CNT_W{1'b1}})) begin
                    FLUSH_COUNT <= FLUSH_COUNT + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ir_pipe_ctrl.sv
// Bench for ir_pipe_ctrl: directed instruction streams, a stage-array reference model
// compared every cycle, a retirement scoreboard and literal spot checks.
module tb_ir_pipe_ctrl;

    localparam int          CNT_W = 4;
    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] I_ADD = 32'h00208033;
    localparam logic [31:0] I_LW5 = 32'h0000A283;
    localparam logic [31:0] I_USE = 32'h00728333;
    localparam logic [31:0] I_LW0 = 32'h0000A003;
    localparam logic [31:0] I_U0  = 32'h00700333;
    localparam logic [31:0] I_LUI = 32'h000012B7;
    localparam logic [31:0] I_BEQ = 32'h00208463;
    localparam logic [31:0] I_ADI = 32'h00100093;
    localparam int          SAT   = (1 << CNT_W) - 1;

    // clock / reset
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic [31:0]      IF_IR = NOP;
    logic [31:0]      IF_PC = 32'd0;
    logic             IF_VALID = 1'b0;
    logic             FLUSH = 1'b0;
    logic             STALL;
    logic [31:0]      DEC_IR, DEC_PC, EXE_IR, EXE_PC, MEM_IR, MEM_PC, WB_IR, WB_PC;
    logic             DEC_IR_EN, EXE_IR_EN, MEM_IR_EN, WB_IR_EN;
    logic [CNT_W-1:0] STALL_COUNT, FLUSH_COUNT;

    ir_pipe_ctrl #(.NOP_INSTR(NOP), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .IF_IR(IF_IR), .IF_PC(IF_PC), .IF_VALID(IF_VALID), .FLUSH(FLUSH),
        .STALL(STALL),
        .DEC_IR(DEC_IR), .DEC_PC(DEC_PC), .EXE_IR(EXE_IR), .EXE_PC(EXE_PC),
        .MEM_IR(MEM_IR), .MEM_PC(MEM_PC), .WB_IR(WB_IR), .WB_PC(WB_PC),
        .DEC_IR_EN(DEC_IR_EN), .EXE_IR_EN(EXE_IR_EN), .MEM_IR_EN(MEM_IR_EN), .WB_IR_EN(WB_IR_EN),
        .STALL_COUNT(STALL_COUNT), .FLUSH_COUNT(FLUSH_COUNT)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: slot 0=DEC 1=EXE 2=MEM 3=WB
    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
        logic        en;
    } slot_t;

    slot_t       m_st[4];
    int          m_scnt;
    int          m_fcnt;
    logic [63:0] exp_q[$];
    bit          chk_en = 1'b0;

    function automatic bit reads_reg(input logic [31:0] ir, input logic [4:0] r);
        logic [6:0] op;
        bit         r1;
        bit         r2;
        op = ir[6:0];
        r1 = (op == 7'h67) || (op == 7'h63) || (op == 7'h03) || (op == 7'h23) ||
             (op == 7'h13) || (op == 7'h33) ||
             ((op == 7'h73) && (ir[14:12] >= 3'd1) && (ir[14:12] <= 3'd3));
        r2 = (op == 7'h63) || (op == 7'h23) || (op == 7'h33);
        return (r1 && ir[19:15] == r) || (r2 && ir[24:20] == r);
    endfunction

    function automatic bit model_stall();
        return m_st[1].en && m_st[1].ir[6:0] == 7'h03 && m_st[1].ir[11:7] != 5'd0 &&
               m_st[0].en && reads_reg(m_st[0].ir, m_st[1].ir[11:7]);
    endfunction

    always @(posedge CLK) begin
        slot_t bub;
        bub.ir = NOP; bub.pc = 32'd0; bub.en = 1'b0;
        if (RST) begin
            for (int i = 0; i < 4; i++) m_st[i] = bub;
            m_scnt = 0;
            m_fcnt = 0;
            exp_q.delete();
        end else if (model_stall()) begin
            m_st[3] = m_st[2];
            m_st[2] = m_st[1];
            m_st[1] = bub;
            if (m_scnt < SAT) m_scnt++;
        end else begin
            for (int i = 3; i > 0; i--) m_st[i] = m_st[i-1];
            if (FLUSH || !IF_VALID) begin
                m_st[0] = bub;
            end else begin
                m_st[0].ir = IF_IR; m_st[0].pc = IF_PC; m_st[0].en = 1'b1;
                exp_q.push_back({IF_PC, IF_IR});
            end
            if (FLUSH && m_fcnt < SAT) m_fcnt++;
        end
    end

    // compare process
    always @(negedge CLK) begin
        if (chk_en) begin
            logic [63:0] e;
            check("stall", STALL, model_stall());
            check("dec_ir", DEC_IR, m_st[0].ir);  check("dec_pc", DEC_PC, m_st[0].pc);
            check("dec_en", DEC_IR_EN, m_st[0].en);
            check("exe_ir", EXE_IR, m_st[1].ir);  check("exe_pc", EXE_PC, m_st[1].pc);
            check("exe_en", EXE_IR_EN, m_st[1].en);
            check("mem_ir", MEM_IR, m_st[2].ir);  check("mem_pc", MEM_PC, m_st[2].pc);
            check("mem_en", MEM_IR_EN, m_st[2].en);
            check("wb_ir", WB_IR, m_st[3].ir);    check("wb_pc", WB_PC, m_st[3].pc);
            check("wb_en", WB_IR_EN, m_st[3].en);
            check("stall_count", STALL_COUNT, m_scnt);
            check("flush_count", FLUSH_COUNT, m_fcnt);
            if (m_st[3].en) begin
                if (exp_q.size() == 0) begin
                    check("retire_q_nonempty", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    check("retire", {WB_PC, WB_IR}, e);
                end
            end
        end
    end

    // driver tasks
    task automatic step(input logic [31:0] ir, input logic [31:0] pc, input logic v,
                        input logic fl);
        IF_IR = ir; IF_PC = pc; IF_VALID = v; FLUSH = fl;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(NOP, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic check_all_empty(input string tag);
        check({tag, "_en"}, {DEC_IR_EN, EXE_IR_EN, MEM_IR_EN, WB_IR_EN}, 4'b0000);
        check({tag, "_irs"}, {DEC_IR, EXE_IR, MEM_IR, WB_IR}, {NOP, NOP, NOP, NOP});
        check({tag, "_cnt"}, {STALL_COUNT, FLUSH_COUNT}, 0);
        check({tag, "_stall"}, STALL, 1'b0);
    endtask

    initial begin
        RST = 1'b1;
        idle(2);
        check_all_empty("reset");
        check("reset_pcs", {DEC_PC, WB_PC}, 64'd0);
        RST = 1'b0;
        chk_en = 1'b1;

        // plain stream: one add walks DEC..WB
        step(I_ADD, 32'h100, 1'b1, 1'b0);
        check("stream_dec_pc", DEC_PC, 32'h100);
        step(NOP, 0, 1'b0, 1'b0);
        check("stream_exe_pc", EXE_PC, 32'h100);
        step(NOP, 0, 1'b0, 1'b0);
        check("stream_mem_pc", MEM_PC, 32'h100);
        step(NOP, 0, 1'b0, 1'b0);
        check("stream_wb", {WB_PC, WB_IR, 31'd0, WB_IR_EN}, {32'h100, I_ADD, 32'd1});

        // load-use: one stall, EXE bubble, use enters EXE a cycle late
        step(I_LW5, 32'h200, 1'b1, 1'b0);
        step(I_USE, 32'h204, 1'b1, 1'b0);
        check("lu_stall_on", STALL, 1'b1);
        step(I_USE, 32'h204, 1'b1, 1'b0);
        check("lu_stall_off", STALL, 1'b0);
        check("lu_exe_bubble", {EXE_IR_EN, EXE_IR}, {1'b0, NOP});
        check("lu_dec_hold", DEC_PC, 32'h204);
        check("lu_mem_load", MEM_IR, I_LW5);
        check("lu_scnt", STALL_COUNT, 1);
        step(NOP, 0, 1'b0, 1'b0);
        check("lu_exe_late", {EXE_PC, EXE_IR}, {32'h204, I_USE});

        // no false hazards: load to x0, and LUI writing the loaded register
        step(I_LW0, 32'h280, 1'b1, 1'b0);
        step(I_U0, 32'h284, 1'b1, 1'b0);
        check("nf_x0", STALL, 1'b0);
        step(I_LW5, 32'h288, 1'b1, 1'b0);
        step(I_LUI, 32'h28c, 1'b1, 1'b0);
        check("nf_lui", STALL, 1'b0);

        // flush: beq in DEC redirects
        step(I_BEQ, 32'h300, 1'b1, 1'b0);
        step(I_ADI, 32'h304, 1'b1, 1'b1);
        check("fl_dec", {DEC_IR_EN, DEC_IR}, {1'b0, NOP});
        check("fl_exe", EXE_IR, I_BEQ);
        check("fl_cnt", FLUSH_COUNT, 1);

        // flush during a stall is ignored
        step(I_LW5, 32'h400, 1'b1, 1'b0);
        step(I_USE, 32'h404, 1'b1, 1'b0);
        check("fs_stall", STALL, 1'b1);
        step(I_ADI, 32'h408, 1'b1, 1'b1);
        check("fs_dec_hold", {DEC_PC, DEC_IR}, {32'h404, I_USE});
        check("fs_cnts", {STALL_COUNT, FLUSH_COUNT}, {4'd2, 4'd1});

        // reset mid-stream drops everything in flight
        step(I_ADI, 32'h500, 1'b1, 1'b0);
        step(I_ADD, 32'h504, 1'b1, 1'b0);
        RST = 1'b1;
        step(I_ADI, 32'h508, 1'b1, 1'b1);
        check_all_empty("midrst");
        RST = 1'b0;

        // counter saturation
        for (int k = 0; k < SAT + 2; k++) begin
            step(I_LW5, 32'h600 + 32'(k * 8), 1'b1, 1'b0);
            step(I_USE, 32'h604 + 32'(k * 8), 1'b1, 1'b0);
            step(I_USE, 32'h604 + 32'(k * 8), 1'b1, 1'b0);
        end
        check("sat_stall", STALL_COUNT, SAT);
        for (int k = 0; k < SAT + 3; k++) step(I_ADI, 32'h800 + 32'(k * 4), 1'b1, 1'b1);
        check("sat_flush", FLUSH_COUNT, SAT);

        idle(6);
        check("retire_q_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
